interval_timer_ctrl: RTL and testbench
======================================

Name: interval_timer_ctrl

Overview:
- Controller that configures, starts, stops and sequences a WIDTH-bit up-counter datapath with a clock prescaler.
- Supports one-shot and periodic expiry.
- Raises a single-cycle expire pulse plus a sticky interrupt with overrun detection.
- Sits between a software-style config/command interface and the counter value consumed by downstream logic.

Parameters:
- WIDTH, 4, counter and period width.
- PRESCALE_W, 4, prescaler compare width; step every (cfg_prescale+1) clk cycles.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready.
- cfg_period  in  WIDTH  terminal count P.
- cfg_prescale  in  PRESCALE_W  prescale value S.
- cfg_mode  in  1  0 = one-shot, 1 = periodic.
- start  in  1  start/restart command, level-sampled.
- stop  in  1  stop command, level-sampled.
- irq_clr  in  1  clears irq and overrun.
- count  out  WIDTH  current counter value.
- busy  out  1  high in RUN.
- expire  out  1  one-cycle pulse on expiry.
- irq  out  1  sticky expiry flag.
- overrun  out  1  sticky: expiry while irq already set.

Behaviour:
- Reset (async, rst=1): state IDLE; count=0; prescaler=0; latched P/S/mode=0; expire=0; irq=0; overrun=0; busy=0; cfg_ready=1. Reset mid-RUN aborts immediately with no expire pulse.
- All outputs are registered or state-decoded. cfg_ready=1 in IDLE, ARMED and DONE; 0 in RUN.
- States and transitions:
  - IDLE: cfg handshake latches P/S/mode, clears count and prescaler, goes to ARMED. start/stop ignored.
  - ARMED:
    - start=1 goes to RUN next edge, with count=0 and prescaler=0.
    - A cfg handshake in the same cycle as start: cfg wins; the new config is latched and the state stays ARMED.
    - stop ignored.
  - RUN: busy=1. Each cycle, prescaler increments. When prescaler==S, a step occurs and prescaler resets to 0.
    - On a step with count!=P: count<=count+1.
    - On a step with count==P: expiry.
      - Periodic: count<=0, stay in RUN.
      - One-shot: count holds P, go to DONE.
    - Expiry interval = (P+1)*(S+1) cycles.
    - P=0: every step expires and count stays 0.
    - S=0: every RUN cycle is a step.
  - stop in RUN: goes to ARMED; count and prescaler cleared; config retained.
    - stop and start asserted together in RUN: stop wins.
    - stop and expiry on the same edge: stop wins; no expire pulse; irq unchanged.
  - start in RUN (without stop): restart, with count=0 and prescaler=0; stays in RUN.
  - DONE:
    - start goes to RUN with count=0 and prescaler=0.
    - A cfg handshake goes to ARMED (cfg wins over start).
    - count holds P until left.
- expire: registered. Asserted for exactly the one cycle following the edge on which the expiry was detected.
- irq: set on expiry.
  - irq_clr clears irq and overrun.
  - Expiry with irq_clr on the same edge: irq=1 (set wins), overrun unchanged.
  - Expiry while irq=1 and no irq_clr: overrun<=1.
- Arithmetic: count never exceeds P and never wraps past 2^WIDTH−1. P=2^WIDTH−1 is legal and expires at all-ones.
- Config changes during RUN are impossible (cfg_ready=0); cfg_valid there is held off, not dropped.

Test Plan:
- Reset/defaults: assert rst mid-run with count=2 → count=0, busy=0, irq=0, overrun=0, cfg_ready=1, expire=0, asynchronously before the next edge.
- Periodic, P=3, S=0:
  - cfg, then start at edge 0 → count sequence 0,1,2,3,0,1…
  - expire high one cycle every 4 cycles.
  - irq=1 after the first expiry; overrun=1 after the second (no irq_clr).
- One-shot with prescale, P=2, S=1: start → count increments every 2 cycles to 2; single expire at 6 cycles after RUN entry.
  - State DONE, busy=0, count holds 2.
  - start re-enters RUN with count=0.
- stop/expire collision, P=1, S=0, periodic: assert stop on the edge where count==1 steps → no expire pulse, irq stays 0, state ARMED, count=0.
- irq handshake, P=0, S=0, periodic:
  - expire every cycle.
  - Pulse irq_clr on an expiry edge → irq stays 1, overrun stays 0.
  - irq_clr on a non-expiry edge is impossible with P=0, so re-run with P=1: irq_clr on the gap cycle → irq=0, overrun=0.
- cfg/ready: cfg_valid held during RUN → cfg_ready=0, no latch. After stop, handshake completes with new P=5 → state ARMED; next start counts to 5.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// Interval timer controller: sequences a prescaled WIDTH-bit up-counter through
// idle/armed/run/done with one-shot or periodic expiry, sticky irq and overrun.
module interval_timer_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_mode,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  irq_clr,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expire,
  output logic                  irq,
  output logic                  overrun
);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]      period_q, period_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  mode_q, mode_d;
  logic                  expire_q, expire_d;
  logic                  irq_q, irq_d;
  logic                  overrun_q, overrun_d;

  logic cfg_fire;
  logic expiry;

  assign cfg_ready = (state_q != StRun);
  assign cfg_fire  = cfg_valid && cfg_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    presc_d    = presc_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    expiry     = 1'b0;

    unique case (state_q)
      StIdle, StArmed, StDone: begin
        // A config handshake always takes priority over start.
        if (cfg_fire) begin
          period_d   = cfg_period;
          prescale_d = cfg_prescale;
          mode_d     = cfg_mode;
          count_d    = '0;
          presc_d    = '0;
          state_d    = StArmed;
        end else if (start && (state_q != StIdle)) begin
          count_d = '0;
          presc_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          // Stop overrides both restart and a coincident expiry.
          count_d = '0;
          presc_d = '0;
          state_d = StArmed;
        end else if (start) begin
          count_d = '0;
          presc_d = '0;
        end else if (presc_q == prescale_q) begin
          presc_d = '0;
          if (count_q == period_q) begin
            expiry = 1'b1;
            if (mode_q) begin
              count_d = '0;
            end else begin
              state_d = StDone;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          presc_d = presc_q + PRESCALE_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    expire_d  = expiry;
    irq_d     = irq_q;
    overrun_d = overrun_q;
    if (expiry) begin
      // Set beats clear; overrun only grows when irq was already pending.
      irq_d = 1'b1;
      if (irq_q && !irq_clr) begin
        overrun_d = 1'b1;
      end
    end else if (irq_clr) begin
      irq_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      presc_q    <= '0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      expire_q   <= 1'b0;
      irq_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      expire_q   <= expire_d;
      irq_q      <= irq_d;
      overrun_q  <= overrun_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == StRun);
  assign expire  = expire_q;
  assign irq     = irq_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Randomized + directed bench for interval_timer_ctrl; a time-based reference model
// feeds a scoreboard queue that a separate monitor drains after every clock edge.
module tb_interval_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_period;
  logic [3:0] cfg_prescale;
  logic       cfg_mode;
  logic       start;
  logic       stop;
  logic       irq_clr;
  logic [3:0] count;
  logic       busy;
  logic       expire;
  logic       irq;
  logic       overrun;

  interval_timer_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_mode     (cfg_mode),
    .start        (start),
    .stop         (stop),
    .irq_clr      (irq_clr),
    .count        (count),
    .busy         (busy),
    .expire       (expire),
    .irq          (irq),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit busy;
    bit expire;
    bit irq;
    bit overrun;
    bit cfg_ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 idle, 1 armed, 2 run, 3 done; time in RUN tracked as t.
  int m_state, m_p, m_s, m_t, m_count;
  bit m_mode, m_irq, m_ovr;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_p = 0; m_s = 0; m_t = 0; m_count = 0;
    m_mode = 0; m_irq = 0; m_ovr = 0;
  endtask

  task automatic cycle(input bit cv, input int p, input int s, input bit md,
                       input bit st, input bit sp, input bit clr);
    bit fire;
    bit ev;
    int len;
    exp_t e;
    @(negedge clk);
    cfg_valid = cv; cfg_period = 4'(p); cfg_prescale = 4'(s); cfg_mode = md;
    start = st; stop = sp; irq_clr = clr;
    fire = cv && (m_state != 2);
    ev   = 0;
    if (m_state != 2) begin
      if (fire) begin
        m_p = p; m_s = s; m_mode = md; m_count = 0; m_state = 1;
      end else if (st && m_state != 0) begin
        m_state = 2; m_t = 0; m_count = 0;
      end
    end else if (sp) begin
      m_state = 1; m_count = 0;
    end else if (st) begin
      m_t = 0; m_count = 0;
    end else begin
      len = (m_p + 1) * (m_s + 1);
      m_t = m_t + 1;
      ev  = (m_t % len) == 0;
      if (!m_mode && m_t == len) begin
        m_state = 3; m_count = m_p;
      end else begin
        m_t = m_t % len;
        m_count = (m_t / (m_s + 1)) % (m_p + 1);
      end
    end
    if (ev) begin
      if (m_irq && !clr) m_ovr = 1;
      m_irq = 1;
    end else if (clr) begin
      m_irq = 0; m_ovr = 0;
    end
    e.count = m_count; e.busy = (m_state == 2); e.expire = ev;
    e.irq = m_irq; e.overrun = m_ovr; e.cfg_ready = (m_state != 2);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset: outputs must settle before the next clock edge.
  task automatic do_reset();
    @(negedge clk);
    cfg_valid = 0; start = 0; stop = 0; irq_clr = 0;
    rst = 1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_expire", int'(expire), 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("count", int'(count), e.count);
        chk("busy", int'(busy), int'(e.busy));
        chk("expire", int'(expire), int'(e.expire));
        chk("irq", int'(irq), int'(e.irq));
        chk("overrun", int'(overrun), int'(e.overrun));
        chk("cfg_ready", int'(cfg_ready), int'(e.cfg_ready));
      end
    end
  end

  initial begin : stimulus
    int p, s;
    rst = 1; cfg_valid = 0; cfg_period = 0; cfg_prescale = 0; cfg_mode = 0;
    start = 0; stop = 0; irq_clr = 0;
    model_reset();
    do_reset();

    // Periodic P=3 S=0; cfg held during RUN, then new P=5 after stop.
    cycle(1, 3, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    idle(9);
    for (int i = 0; i < 3; i++) cycle(1, 5, 0, 0, 0, 0, 0);
    cycle(1, 5, 0, 0, 0, 1, 0);
    cycle(1, 5, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 1);
    idle(8);

    // One-shot P=2 S=1, then restart from DONE.
    cycle(1, 2, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    idle(9);
    cycle(0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Stop colliding with expiry, P=1 S=0 periodic.
    cycle(1, 1, 0, 1, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    idle(1);
    cycle(0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // P=0: expiry every cycle, irq_clr on an expiry edge; then P=1 clear on gap.
    cycle(1, 0, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 1);
    cycle(1, 1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // All-ones period with prescale.
    cycle(1, 15, 2, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    idle(52);

    // Reset mid-run with count=2.
    cycle(1, 5, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    idle(2);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(0, 15);
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 7) == 0, p, s, 1'($urandom_range(0, 1)),
              $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 9) == 0);
      end
    end

    idle(1);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
